// File: rtl/instr_fetch_unit_if.sv
// Program-load, redirect and decode-handshake signals of the instruction fetch unit.
// The fetch unit takes the slave side; the CPU/loader drives the master side.
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 9
);
   logic               prog_we;
   logic [ADDR_W-1:0]  prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic               fetch_halted;

   modport master (
      output prog_we, prog_addr, prog_data, redirect, redirect_pc, instr_ready,
      input  instr_valid, instr, instr_pc, fetch_halted
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, redirect, redirect_pc, instr_ready,
      output instr_valid, instr, instr_pc, fetch_halted
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Writable instruction memory with a one-stage read and a prefetch FIFO feeding decode.
// Fetch stops by itself once a halt word is pushed; a redirect flushes and restarts it.
//
// state    | meaning
// S_RUN    | issuing sequential reads while the FIFO has room
// S_HALTED | halt word pushed; no issues until the next redirect
module instr_fetch_unit #(
   parameter int                ADDR_W     = 16,
   parameter int                INSTR_W    = 9,
   parameter int                OPC_W      = 5,
   parameter int                DEPTH      = 64,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [OPC_W-1:0]  HALT_OPC   = 5'b11010,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input logic              clk,
   input logic              rst_n,
   instr_fetch_unit_if.slave bus
);
   localparam logic [INSTR_W-1:0] HALT_WORD = {HALT_OPC, {(INSTR_W-OPC_W){1'b0}}};
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W  = $clog2(FIFO_DEPTH);

   typedef enum logic {S_RUN, S_HALTED} state_t;

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic               rd_v_q, rd_v_d;
   logic [INSTR_W-1:0] rd_word_q, rd_word_d;
   logic [ADDR_W-1:0]  rd_pc_q, rd_pc_d;
   logic [INSTR_W-1:0] fifo_instr_q [FIFO_DEPTH];
   logic [INSTR_W-1:0] fifo_instr_d [FIFO_DEPTH];
   logic [ADDR_W-1:0]  fifo_pc_q [FIFO_DEPTH];
   logic [ADDR_W-1:0]  fifo_pc_d [FIFO_DEPTH];
   logic [CNT_W-1:0]   count_q, count_d;

   logic               in_range;
   logic [INSTR_W-1:0] mem_rd;
   logic               pop, push, halt_push, issue;
   logic [IDX_W-1:0]   wr_idx;

   // Words are stored XOR the halt word so a zeroed power-up array reads back as halt.
   always_ff @(posedge clk) begin
      if (bus.prog_we && (32'(bus.prog_addr) < DEPTH))
         mem_q[bus.prog_addr[MEM_AW-1:0]] <= bus.prog_data ^ HALT_WORD;
   end

   assign in_range  = 32'(fetch_pc_q) < DEPTH;
   assign mem_rd    = in_range ? (mem_q[fetch_pc_q[MEM_AW-1:0]] ^ HALT_WORD) : HALT_WORD;
   assign pop       = (count_q != '0) && bus.instr_ready && !bus.redirect;
   assign push      = rd_v_q && !bus.redirect;
   assign halt_push = push && (rd_word_q[INSTR_W-1 -: OPC_W] == HALT_OPC);
   assign issue     = (state_q == S_RUN) && !bus.redirect && !halt_push
                      && ((32'(count_q) + 32'(rd_v_q)) < FIFO_DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.redirect)   state_d = S_RUN;
      else if (halt_push) state_d = S_HALTED;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_v_d     = issue;
      rd_word_d  = rd_word_q;
      rd_pc_d    = rd_pc_q;
      if (bus.redirect) begin
         fetch_pc_d = bus.redirect_pc;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(1);
         rd_word_d  = mem_rd;
         rd_pc_d    = fetch_pc_q;
      end
   end

   // Head lives in entry 0; popping the only entry leaves it in place so the outputs hold.
   always_comb begin
      fifo_instr_d = fifo_instr_q;
      fifo_pc_d    = fifo_pc_q;
      count_d      = count_q;
      wr_idx       = IDX_W'(count_q - CNT_W'(pop));
      if (bus.redirect) begin
         count_d = '0;
      end else begin
         if (pop && (count_q > CNT_W'(1))) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
               fifo_instr_d[i] = fifo_instr_q[i+1];
               fifo_pc_d[i]    = fifo_pc_q[i+1];
            end
         end
         if (push) begin
            fifo_instr_d[wr_idx] = rd_word_q;
            fifo_pc_d[wr_idx]    = rd_pc_q;
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rd_v_q     <= 1'b0;
         rd_word_q  <= HALT_WORD;
         rd_pc_q    <= '0;
         count_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr_q[i] <= HALT_WORD;
            fifo_pc_q[i]    <= '0;
         end
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         rd_v_q       <= rd_v_d;
         rd_word_q    <= rd_word_d;
         rd_pc_q      <= rd_pc_d;
         count_q      <= count_d;
         fifo_instr_q <= fifo_instr_d;
         fifo_pc_q    <= fifo_pc_d;
      end
   end

   assign bus.instr_valid  = (count_q != '0);
   assign bus.instr        = fifo_instr_q[0];
   assign bus.instr_pc     = fifo_pc_q[0];
   assign bus.fetch_halted = (state_q == S_HALTED);
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised successor to the fixed instruction ROM. Holds the program in a writable instruction memory, fetches sequentially from a program counter, and buffers fetched words in a small prefetch FIFO. Hands {pc, instruction} to the decode stage of the pipelined CPU over a valid/ready handshake, supports branch/jump redirect, and stops fetching on its own when it fetches a halt instruction.

## Interface
- ADDR_W, 16, PC and address width
- INSTR_W, 9, instruction width as {opcode, operand}
- OPC_W, 5, opcode width (upper bits of the instruction)
- DEPTH, 64, instruction memory words; DEPTH <= 2**ADDR_W
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >= 2
- HALT_OPC, 5'b11010, halt opcode; halt word = {HALT_OPC, {INSTR_W-OPC_W{1'b0}}}
- RESET_PC, 0, fetch start address after reset
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- prog_we  in  1  write enable for the instruction memory
- prog_addr  in  ADDR_W  write address
- prog_data  in  INSTR_W  write data
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr  out  INSTR_W  FIFO head instruction
- instr_pc  out  ADDR_W  address of the head instruction
- fetch_halted  out  1  fetch engine is in HALTED

## Operation
- Memory: DEPTH x INSTR_W. Every entry initialises to the halt word at time zero. rst_n does not clear memory.
- Programming: if prog_we is high and prog_addr < DEPTH, the memory writes mem[prog_addr] on the clock edge. Writes with prog_addr >= DEPTH are ignored. Writes are accepted in any state.
- Read-during-write to the same address returns the old data. A write is guaranteed visible only to fetches issued after a later redirect.
- Read pipeline has one stage. An issue at edge k loads rd_word = (fetch_pc < DEPTH ? mem[fetch_pc] : halt word), rd_pc = fetch_pc, rd_v = 1, and sets fetch_pc = fetch_pc + 1 (mod 2**ADDR_W).
- Issue condition: state RUN, and (fifo_count + rd_v) < FIFO_DEPTH. The condition is conservative and ignores a same-cycle pop. Sustained rate is still one instruction per cycle.
- Push: at any edge where rd_v = 1 and no redirect is asserted, {rd_pc, rd_word} enters the FIFO. The condition above guarantees the FIFO never overflows.
- Halt: if the pushed word's opcode equals HALT_OPC:
  - the halt word is still pushed;
  - state goes to HALTED;
  - rd_v is cleared, discarding any read issued at the same edge;
  - no further issues occur.
- States:
  - RUN to HALTED on a halt push.
  - HALTED to RUN on redirect.
  - RUN to RUN on redirect.
- Redirect at edge R, in any state and with priority over everything else:
  - FIFO emptied;
  - rd_v cleared;
  - fetch_pc = redirect_pc;
  - state = RUN;
  - a same-edge pop or push is discarded.
- Pop: instr_valid && instr_ready && !redirect. The FIFO advances one entry.
- Outputs instr, instr_pc and instr_valid come straight from the FIFO head registers, with no combinational path from the inputs. When instr_valid = 0, instr and instr_pc hold their last values.
- fetch_halted = (state == HALTED).

## Timing
- Values forced while rst_n = 0:
  - instr_valid = 0, instr = halt word, instr_pc = 0, fetch_halted = 0;
  - fifo_count = 0, rd_v = 0, fetch_pc = RESET_PC, state RUN.
- After rst_n rises:
  - first issue at the first clock edge;
  - push at the second edge;
  - instr_valid = 1 after the second edge, with instr_pc = RESET_PC.
- Redirect latency: redirect sampled at edge R gives the first issue at R+1 and instr_valid with instr_pc = redirect_pc after R+2. instr_valid is 0 from after R until R+2.
- With instr_ready held high, consecutive pcs appear one per cycle.
- With instr_ready low, the FIFO fills to exactly FIFO_DEPTH. The last issue happens when count + rd_v reaches FIFO_DEPTH, and the engine then waits.
- fetch_halted rises in the cycle after the halt word's push edge.
- rst_n asserted mid-operation forces the reset values immediately. In-flight reads and FIFO contents are lost. Memory is retained.

## Test plan
- Reset and stream:
  - Stimulus: program mem[0..3] = 0x0C0, 0x120, 0x190, 0x1A0 (last is halt); RESET_PC = 0; instr_ready = 1.
  - Response: instr_valid after the second edge; pcs 0, 1, 2, 3 on consecutive cycles; fetch_halted = 1; instr_valid = 0 after pc 3 is popped.
- Backpressure:
  - Stimulus: mem[0..9] non-halt; instr_ready = 0 for 10 cycles, then 1.
  - Response: count holds at 4; pcs 0 through 9 delivered in order with none lost or duplicated.
- Redirect mid-stream:
  - Stimulus: redirect with redirect_pc = 20 while pcs 2 and 3 are buffered and instr_ready = 1.
  - Response: pcs 2 and 3 are never delivered; next valid instr_pc = 20 after R+2.
- Out of range:
  - Stimulus: DEPTH = 64; redirect_pc = 62; mem[62] and mem[63] non-halt.
  - Response: pcs 62, 63, then 64 carrying the halt word; fetch_halted = 1.
- Program and restart:
  - Stimulus: while HALTED, write mem[5] = 0x0A3 with prog_addr = 100 also written; then redirect_pc = 5.
  - Response: instr = 0x0A3 at pc 5; the write to address 100 leaves memory unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 between edges while the FIFO holds 3 entries.
  - Response: instr_valid = 0 immediately; after release, the restart delivers RESET_PC first with the programmed contents intact.
